spi_pad_poller: RTL

SPI_PAD_POLLER -- requirements
Module: spi_pad_poller

---
 rtl/spi_pad_poller_pkg.sv | 49 ++++
 rtl/spi_poll_timer.sv | 56 +++++
 rtl/spi_pad_poller.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_pad_poller_pkg.sv
// Shared definitions for the SPI game-pad poller: FSM encoding, frame
// layout and the fixed command/ack bytes exchanged with the pad.
package spi_pad_poller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SEND,
    ST_WAIT_RX,
    ST_GAP,
    ST_CS_HOLD,
    ST_FINISH
  } state_e;

  localparam int unsigned FRAME_LEN = 5;
  localparam int unsigned IDX_W     = 3;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(FRAME_LEN - 1);

  // Bytes sent to the pad, and the byte the pad returns to acknowledge.
  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_POLL  = 8'h42;
  localparam logic [7:0] CMD_IDLE  = 8'h00;
  localparam logic [7:0] ACK_BYTE  = 8'h5A;

  // Positions of the interesting bytes in the received frame.
  localparam idx_t IDX_PAD_ID = idx_t'(1);
  localparam idx_t IDX_ACK    = idx_t'(2);
  localparam idx_t IDX_BTN_LO = idx_t'(3);
  localparam idx_t IDX_BTN_HI = idx_t'(4);

  // Byte transmitted at a given frame position.
  function automatic logic [7:0] cmd_byte(input idx_t idx);
    case (idx)
      idx_t'(0): return CMD_START;
      idx_t'(1): return CMD_POLL;
      default:   return CMD_IDLE;
    endcase
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_poll_timer.sv
// Periodic poll timer plus the single pending-request flag. Timer wraps and
// manual requests both land in the same flag, so any number of requests
// raised while a poll is running collapse into one follow-up poll.
module spi_poll_timer #(
  parameter int unsigned c_POLL_PERIOD = 833333
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic poll_now_i,
  input  logic take_i,
  output logic pending_o
);

  localparam int unsigned CNT_W = (c_POLL_PERIOD > 1) ? $clog2(c_POLL_PERIOD) : 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(c_POLL_PERIOD - 1);

  cnt_t cnt_q, cnt_d;
  logic pending_q, pending_d;
  logic wrap;

  // Next-state for the period counter and the pending flag.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch can be inferred.
    cnt_d     = cnt_q;
    pending_d = pending_q;
    wrap      = enable_i && (cnt_q == CNT_LAST);

    if (!enable_i) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + cnt_t'(1);
    end

    // A new request in the same cycle as the take wins, so it is not lost.
    pending_d = (pending_q && !take_i) || wrap || poll_now_i;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/spi_pad_poller.sv
// Polls a game pad over an SPI byte master: drops chip select, exchanges a
// five-byte frame (01 42 00 00 00), checks the ack byte and publishes the
// button state and pad ID of every good frame.
module spi_pad_poller
  import spi_pad_poller_pkg::*;
#(
  parameter int unsigned c_POLL_PERIOD = 833333,
  parameter int unsigned c_CS_SETUP    = 50,
  parameter int unsigned c_BYTE_GAP    = 100,
  parameter int unsigned c_TIMEOUT     = 1000
) (
  input  logic        i_CLK,
  input  logic        i_RESET_N,
  input  logic        i_ENABLE,
  input  logic        i_POLL_NOW,
  output logic [7:0]  o_TX_BYTE,
  output logic        o_TX_DV,
  input  logic        i_TX_READY,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_BYTE,
  output logic        o_CS_N,
  output logic [15:0] o_BUTTONS,
  output logic [7:0]  o_PAD_ID,
  output logic        o_POLL_DONE,
  output logic        o_ERROR
);

  localparam int unsigned CNT_MAX = max3(c_CS_SETUP, c_BYTE_GAP, c_TIMEOUT);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t SETUP_LAST   = cnt_t'(c_CS_SETUP - 1);
  localparam cnt_t GAP_LAST     = cnt_t'(c_BYTE_GAP - 1);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(c_TIMEOUT - 1);

  state_e                      state_q;
  cnt_t                        cnt_q;
  idx_t                        idx_q;
  logic [FRAME_LEN-1:0][7:0]   frame_q;
  logic [7:0]                  tx_byte_q;
  logic                        cs_n_q;
  logic [15:0]                 buttons_q;
  logic [7:0]                  pad_id_q;
  logic                        poll_done_q;
  logic                        error_q;

  logic poll_pending;
  logic poll_take;

  assign poll_take = (state_q == ST_IDLE) && poll_pending;

  spi_poll_timer #(
    .c_POLL_PERIOD(c_POLL_PERIOD)
  ) u_poll_timer (
    .clk_i      (i_CLK),
    .rst_ni     (i_RESET_N),
    .enable_i   (i_ENABLE),
    .poll_now_i (i_POLL_NOW),
    .take_i     (poll_take),
    .pending_o  (poll_pending)
  );

  // Frame sequencer; every externally visible result is registered on the
  // transition into FINISH so it is already valid during the FINISH cycle.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      // NOTE: the frame buffer is plain flops, not a RAM, so it is reset with everything else and never feeds X into the ack compare.
      frame_q     <= '0;
      tx_byte_q   <= '0;
      cs_n_q      <= 1'b1;
      buttons_q   <= '0;
      pad_id_q    <= '0;
      poll_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      poll_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (poll_pending) begin
            state_q <= ST_CS_SETUP;
            cs_n_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end

        ST_CS_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            state_q   <= ST_SEND;
            tx_byte_q <= cmd_byte(idx_q);
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end

        ST_SEND: begin
          // The timeout count starts at 1 here so the FINISH cycle lands exactly
          // c_TIMEOUT clocks after the strobe.
          if (i_TX_READY) begin
            state_q <= ST_WAIT_RX;
            cnt_q   <= cnt_t'(1);
          end
        end

        ST_WAIT_RX: begin
          if (i_RX_DV) begin
            frame_q[idx_q] <= i_RX_BYTE;
            cnt_q          <= '0;
            state_q        <= (idx_q == LAST_IDX) ? ST_CS_HOLD : ST_GAP;
          end else if (cnt_q >= TIMEOUT_LAST) begin
            state_q     <= ST_FINISH;
            cs_n_q      <= 1'b1;
            poll_done_q <= 1'b1;
            error_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end

        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q   <= ST_SEND;
            idx_q     <= idx_q + idx_t'(1);
            tx_byte_q <= cmd_byte(idx_q + idx_t'(1));
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end

        ST_CS_HOLD: begin
          if (cnt_q == SETUP_LAST) begin
            state_q     <= ST_FINISH;
            cs_n_q      <= 1'b1;
            poll_done_q <= 1'b1;
            if (frame_q[IDX_ACK] == ACK_BYTE) begin
              // Pad reports buttons active-low; publish them active-high.
              buttons_q <= ~{frame_q[IDX_BTN_HI], frame_q[IDX_BTN_LO]};
              pad_id_q  <= frame_q[IDX_PAD_ID];
              error_q   <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end

        ST_FINISH: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The strobe is decoded from the registered state and the live ready so it
  // can only ever be high in a cycle where the byte master is ready.
  assign o_TX_DV     = (state_q == ST_SEND) && i_TX_READY;
  assign o_TX_BYTE   = tx_byte_q;
  assign o_CS_N      = cs_n_q;
  assign o_BUTTONS   = buttons_q;
  assign o_PAD_ID    = pad_id_q;
  assign o_POLL_DONE = poll_done_q;
  assign o_ERROR     = error_q;

endmodule
